conv_mac_seq: RTL and testbench



---
 rtl/conv_mac_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_conv_mac_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_seq.sv
// -----------------------------------------------------------------------------
// conv_mac_seq
//
// Sequencer that time-shares one external signed WIDTH x WIDTH multiplier to
// compute one convolution-window dot product of TAPS pixel/weight pairs.
// Pairs arrive serially on a valid/ready stream. Each accepted pair is
// registered onto the multiplier operands, and the product returned on
// mul_p_i is folded into a signed OUT_WIDTH accumulator on the following
// cycle. One result per window leaves on a valid/ready output, with optional
// ReLU selected by relu_en_i at tap 0.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous abort back to IDLE (no accept in that cycle)
//   in_valid_i   input pair valid
//   in_ready_o   input pair accepted when in_valid_i & in_ready_o
//   in_pixel_i   signed pixel
//   in_weight_i  signed weight
//   relu_en_i    ReLU enable, sampled with tap 0 of each window
//   mul_a_o      registered multiplier operand A (pixel)
//   mul_b_o      registered multiplier operand B (weight)
//   mul_p_i      combinational product mul_a_o * mul_b_o, sign-extended
//   out_valid_o  window result valid
//   out_ready_i  result consumed when out_valid_o & out_ready_i
//   out_data_o   signed window sum, after ReLU if enabled
//   tap_idx_o    index of the next pair to be accepted (0..TAPS-1)
//   busy_o       high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module conv_mac_seq #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 20,
  parameter int TAPS      = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_pixel_i,
  input  logic [WIDTH-1:0]     in_weight_i,
  input  logic                 relu_en_i,
  output logic [WIDTH-1:0]     mul_a_o,
  output logic [WIDTH-1:0]     mul_b_o,
  input  logic [OUT_WIDTH-1:0] mul_p_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [3:0]           tap_idx_o,
  output logic                 busy_o
);

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] FIRST_TAP = 4'd0;
  localparam logic [3:0] LAST_TAP  = 4'(TAPS - 1);

  // State and registered outputs
  logic [1:0]           state_q,     state_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q,      busy_d;
  logic [3:0]           tap_idx_q,   tap_idx_d;

  // Multiply pipeline flags: describe the pair currently on mul_a/mul_b
  logic                 p_vld_q,     p_vld_d;
  logic                 p_first_q,   p_first_d;
  logic                 p_last_q,    p_last_d;
  logic                 relu_q,      relu_d;

  // Datapath registers
  logic [WIDTH-1:0]     mul_a_q,     mul_a_d;
  logic [WIDTH-1:0]     mul_b_q,     mul_b_d;
  logic [OUT_WIDTH-1:0] acc_q,       acc_d;
  logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;

  // Combinational helpers
  logic                 accept_s;
  logic                 first_tap_s;
  logic                 last_tap_s;
  logic                 handshake_s;
  logic [OUT_WIDTH-1:0] sum_s;

  // Handshake qualifiers; clear suppresses any accept in its cycle
  always_comb begin
    accept_s    = in_valid_i & in_ready_q & ~clear_i;
    first_tap_s = (tap_idx_q == FIRST_TAP);
    last_tap_s  = (tap_idx_q == LAST_TAP);
    handshake_s = out_valid_q & out_ready_i;
  end

  // Window sum including the product now on mul_p_i; the first tap
  // replaces the accumulator so no residue of a previous window survives
  always_comb begin
    if (p_first_q) begin
      sum_s = mul_p_i;
    end else begin
      sum_s = acc_q + mul_p_i;
    end
  end

  // Next-state logic of the sequencer
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = last_tap_s ? ST_DRAIN : ST_MAC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MAC: begin
          if (accept_s && last_tap_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_MAC;
          end
        end
        ST_DRAIN: begin
          state_d = ST_DONE;
        end
        ST_DONE: begin
          // out_valid is raised one cycle into DONE, so leaving DONE
          // needs an actual handshake and not just out_ready_i
          if (handshake_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Registered status outputs derived from the upcoming state
  always_comb begin
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_MAC);
    busy_d     = (state_d != ST_IDLE);
    // out_data is written on the DRAIN->DONE edge; valid follows one
    // cycle later and then holds until the handshake
    if (clear_i) begin
      out_valid_d = 1'b0;
    end else if (state_q == ST_DONE) begin
      out_valid_d = ~handshake_s;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Tap counter and multiply pipeline flags
  always_comb begin
    if (clear_i) begin
      tap_idx_d = 4'd0;
      p_vld_d   = 1'b0;
      p_first_d = 1'b0;
      p_last_d  = 1'b0;
    end else if (accept_s) begin
      tap_idx_d = last_tap_s ? 4'd0 : (tap_idx_q + 4'd1);
      p_vld_d   = 1'b1;
      p_first_d = first_tap_s;
      p_last_d  = last_tap_s;
    end else begin
      tap_idx_d = tap_idx_q;
      p_vld_d   = 1'b0;
      p_first_d = 1'b0;
      p_last_d  = 1'b0;
    end
  end

  // Operand capture and ReLU mode latch on accept
  always_comb begin
    if (accept_s) begin
      mul_a_d = in_pixel_i;
      mul_b_d = in_weight_i;
    end else begin
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
    end
    if (accept_s && first_tap_s) begin
      relu_d = relu_en_i;
    end else begin
      relu_d = relu_q;
    end
  end

  // Accumulation and result capture; clear leaves both registers untouched
  always_comb begin
    if (!clear_i && p_vld_q) begin
      acc_d = sum_s;
    end else begin
      acc_d = acc_q;
    end
    if (!clear_i && p_last_q) begin
      if (relu_q && sum_s[OUT_WIDTH-1]) begin
        out_data_d = {OUT_WIDTH{1'b0}};
      end else begin
        out_data_d = sum_s;
      end
    end else begin
      out_data_d = out_data_q;
    end
  end

  // State, control and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      tap_idx_q   <= 4'd0;
      p_vld_q     <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      relu_q      <= 1'b0;
      mul_a_q     <= {WIDTH{1'b0}};
      mul_b_q     <= {WIDTH{1'b0}};
      acc_q       <= {OUT_WIDTH{1'b0}};
      out_data_q  <= {OUT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      tap_idx_q   <= tap_idx_d;
      p_vld_q     <= p_vld_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      relu_q      <= relu_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign tap_idx_o   = tap_idx_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_conv_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_conv_mac_seq
//
// Self-checking bench for conv_mac_seq (TAPS=9). Models the external
// multiplier, keeps a scoreboard of expected window results, and runs one
// task per scenario. Inputs are driven and outputs sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_conv_mac_seq;

  localparam int TAPS = 9;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clear     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        relu_en   = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_pixel  = 8'd0;
  logic [7:0]  in_weight = 8'd0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [19:0] mul_p;
  logic [19:0] out_data;
  logic [3:0]  tap_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  // Multiplier model: sign-extend both operands, keep the low 20 bits
  assign mul_p = {{12{mul_a[7]}}, mul_a} * {{12{mul_b[7]}}, mul_b};

  conv_mac_seq #(.WIDTH(8), .OUT_WIDTH(20), .TAPS(TAPS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pixel_i  (in_pixel),
    .in_weight_i (in_weight),
    .relu_en_i   (relu_en),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_p_i     (mul_p),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .tap_idx_o   (tap_idx),
    .busy_o      (busy)
  );

  // Accept counter seen from the bus side
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready && !clear) n_acc <= n_acc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] window_sum(input int px[TAPS], input int wt[TAPS], input bit relu);
    int s;
    logic [19:0] r;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += px[i] * wt[i];
    r = s[19:0];
    if (relu && s < 0) r = 20'd0;
    return r;
  endfunction

  // Drive one pair (called at a falling edge); returns at the falling edge after its accept
  task automatic send_pair(input int p, input int w, input bit r);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_pixel  = 8'(p);
    in_weight = 8'(w);
    relu_en   = r;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send_pair: in_ready stayed %b for 50 cycles, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // relu_en carries the window's mode only at tap 0; other taps drive the opposite
  task automatic send_window(input int px[TAPS], input int wt[TAPS], input bit relu, input int max_gap);
    for (int i = 0; i < TAPS; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_pair(px[i], wt[i], (i == 0) ? relu : !relu);
    end
    relu_en = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid: out_valid=%b after 40 cycles, required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: ready/valid/busy=%b required 000", {in_ready, out_valid, busy});
    end
    n_cmp++;
    if ({tap_idx, mul_a, mul_b, out_data} !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_regs: tap=%0d a=%h b=%h data=%h required all 0", tap_idx, mul_a, mul_b, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int px[TAPS];
    int wt[TAPS];
    int low, hi, rise, base;
    logic [19:0] e;
    for (int i = 0; i < TAPS; i++) begin px[i] = 2; wt[i] = 1; end
    out_ready = 1'b1;
    exp_q.push_back(20'd18);
    base = n_acc;
    send_window(px, wt, 1'b0, 0);
    low = 0; hi = 0; rise = -1;
    for (int k = 0; k < 6; k++) begin
      if (in_ready === 1'b0) low++;
      if (out_valid === 1'b1) begin
        hi++;
        if (rise < 0) begin
          rise = k;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
          n_cmp++;
          if (out_data !== e) begin
            n_bad++;
            $display("FAIL basic_data: out_data=%h required %h", out_data, e);
          end
          n_cmp++;
          if (n_acc - base != TAPS) begin
            n_bad++;
            $display("FAIL basic_accepts: %0d accepts required %0d", n_acc - base, TAPS);
          end
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (rise != 2) begin
      n_bad++;
      $display("FAIL basic_latency: out_valid rose %0d edges after last accept, required 2", rise);
    end
    n_cmp++;
    if (hi != 1) begin
      n_bad++;
      $display("FAIL basic_valid_len: out_valid high %0d cycles, required 1", hi);
    end
    n_cmp++;
    if (low != 3) begin
      n_bad++;
      $display("FAIL basic_ready_gap: in_ready low %0d cycles, required 3", low);
    end
  endtask

  task automatic run_const_window(input string name, input int p, input int w, input bit relu, input logic [19:0] e);
    int px[TAPS];
    int wt[TAPS];
    bit ok;
    logic [19:0] got;
    for (int i = 0; i < TAPS; i++) begin px[i] = p; wt[i] = w; end
    exp_q.push_back(e);
    send_window(px, wt, relu, 0);
    wait_valid(ok);
    if (ok) begin
      got = exp_q.pop_front();
      n_cmp++;
      if (out_data !== got) begin
        n_bad++;
        $display("FAIL %s: out_data=%h required %h", name, out_data, got);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    run_const_window("neg_neg", -128, -128, 1'b0, 20'h24000);
    run_const_window("neg_pos", -128, 127, 1'b0, 20'hDC480);
    run_const_window("neg_pos_relu", -128, 127, 1'b1, 20'h00000);
  endtask

  task automatic test_backpressure();
    int px[TAPS];
    int wt[TAPS];
    bit ok;
    logic [19:0] e;
    for (int i = 0; i < TAPS; i++) begin px[i] = 3; wt[i] = 4; end
    out_ready = 1'b0;
    exp_q.push_back(20'd108);
    send_window(px, wt, 1'b0, 0);
    wait_valid(ok);
    if (ok) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (out_data !== e || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_hold[%0d]: data=%h valid=%b ready=%b busy=%b required %h 1 0 1",
                   k, out_data, out_valid, in_ready, busy, e);
        end
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || tap_idx !== 4'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: ready=%b tap=%0d valid=%b required 1 0 0", in_ready, tap_idx, out_valid);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(7, 7, 1'b0);
    n_cmp++;
    if (tap_idx !== 4'd4) begin
      n_bad++;
      $display("FAIL clear_pre_tap: tap_idx=%0d required 4", tap_idx);
    end
    in_valid = 1'b1; in_pixel = 8'd9; in_weight = 8'd9; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (tap_idx !== 4'd0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_state: tap=%0d busy=%b ready=%b valid=%b required 0 0 1 0",
               tap_idx, busy, in_ready, out_valid);
    end
    n_cmp++;
    if (mul_a !== 8'd7 || mul_b !== 8'd7) begin
      n_bad++;
      $display("FAIL clear_no_accept: mul_a=%h mul_b=%h required 07 07", mul_a, mul_b);
    end
    run_const_window("clear_next", 3, -5, 1'b0, 20'hFFF79);
  endtask

  task automatic test_random();
    int px[TAPS];
    int wt[TAPS];
    bit relu, ok;
    int base;
    logic [19:0] e;
    for (int w = 0; w < 100; w++) begin
      for (int i = 0; i < TAPS; i++) begin
        px[i] = int'($urandom_range(0, 255)) - 128;
        wt[i] = int'($urandom_range(0, 255)) - 128;
      end
      relu = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(window_sum(px, wt, relu));
      base = n_acc;
      send_window(px, wt, relu, 2);
      wait_valid(ok);
      if (ok) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e) begin
          n_bad++;
          $display("FAIL random_data[%0d]: out_data=%h required %h", w, out_data, e);
        end
        n_cmp++;
        if (n_acc - base != TAPS) begin
          n_bad++;
          $display("FAIL random_accepts[%0d]: %0d accepts required %0d", w, n_acc - base, TAPS);
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_pair(4, 4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000 || tap_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL async_flags: ready/valid/busy=%b tap=%0d required 000 0", {in_ready, out_valid, busy}, tap_idx);
    end
    n_cmp++;
    if ({mul_a, mul_b, out_data} !== 36'd0) begin
      n_bad++;
      $display("FAIL async_regs: a=%h b=%h data=%h required 0", mul_a, mul_b, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_const_window("async_next", 1, 1, 1'b0, 20'd9);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
